vx_ahb_mem_arbiter: RTL and testbench

- Shares one Vortex-to-AHB memory adapter between NUM_REQS Vortex memory requesters (e.g. I-cache, D-cache, DMA).
- The adapter handles exactly one 512-bit transaction at a time and returns no tag. This block therefore:
  - serialises requests with a round-robin policy;
  - keeps one transaction outstanding;
  - routes the response back to its owner with the original tag restored.
- A watchdog recovers from the adapter's error path, where no response is returned.

---
 rtl/vx_ahb_arb_pkg.sv | 15 +
 rtl/vx_rr_picker.sv | 28 ++
 rtl/vx_ahb_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_vx_ahb_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_ahb_arb_pkg.sv
// Shared state encoding and helpers for the Vortex-to-AHB memory arbiter.
package vx_ahb_arb_pkg;

    typedef enum logic [1:0] {
        ARB      = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_t;

    // Next round-robin start position after a grant to idx.
    function automatic int rr_next(input int idx, input int num);
        return (idx + 1 >= num) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/vx_rr_picker.sv
// Combinational round-robin priority encoder: first valid requester at or after rr_ptr.
module vx_rr_picker
#(
    parameter int NUM_REQS = 4,
    parameter int IDX_W    = 2
)
(
    input  logic [NUM_REQS-1:0] valid,
    input  logic [IDX_W-1:0]    rr_ptr,
    output logic                grant_valid,
    output logic [IDX_W-1:0]    grant_idx
);

    // Scan offsets from farthest to nearest so the nearest valid offset is written last and wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            idx         = (int'(rr_ptr) + k >= NUM_REQS) ? (int'(rr_ptr) + k - NUM_REQS)
                                                         : (int'(rr_ptr) + k);
            grant_valid = grant_valid | valid[idx];
            grant_idx   = valid[idx] ? IDX_W'(idx) : grant_idx;
        end
    end

endmodule

// File: rtl/vx_ahb_mem_arbiter.sv
// Round-robin arbiter sharing one tagless, single-outstanding AHB memory adapter
// between several Vortex requesters, with tag restoration and a response watchdog.
module vx_ahb_mem_arbiter
    import vx_ahb_arb_pkg::*;
#(
    parameter int NUM_REQS   = 4,
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 26,
    parameter int TAG_WIDTH  = 8,
    parameter int TIMEOUT    = 256
)
(
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQS-1:0]                  in_req_valid,
    input  logic [NUM_REQS-1:0]                  in_req_rw,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]       in_req_addr,
    input  logic [NUM_REQS*DATA_WIDTH-1:0]       in_req_data,
    input  logic [NUM_REQS*(DATA_WIDTH/8)-1:0]   in_req_byteen,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]        in_req_tag,
    output logic [NUM_REQS-1:0]                  in_req_ready,
    output logic [NUM_REQS-1:0]                  in_rsp_valid,
    output logic [DATA_WIDTH-1:0]                in_rsp_data,
    output logic [TAG_WIDTH-1:0]                 in_rsp_tag,
    input  logic [NUM_REQS-1:0]                  in_rsp_ready,
    output logic                                 out_req_valid,
    output logic                                 out_req_rw,
    output logic [ADDR_WIDTH-1:0]                out_req_addr,
    output logic [DATA_WIDTH-1:0]                out_req_data,
    output logic [DATA_WIDTH/8-1:0]              out_req_byteen,
    output logic [TAG_WIDTH-1:0]                 out_req_tag,
    input  logic                                 out_req_ready,
    input  logic                                 out_rsp_valid,
    input  logic [DATA_WIDTH-1:0]                out_rsp_data,
    output logic                                 out_rsp_ready,
    output logic                                 err_valid,
    output logic [$clog2(NUM_REQS)-1:0]          err_id
);

    localparam int IDX_W   = $clog2(NUM_REQS);
    localparam int BE_W    = DATA_WIDTH / 8;
    localparam int WD_W    = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef struct packed {
        logic                  rw;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [BE_W-1:0]       byteen;
        logic [TAG_WIDTH-1:0]  tag;
    } payload_t;

    arb_state_t        state_r;
    logic [IDX_W-1:0]  rr_ptr_r;
    logic [IDX_W-1:0]  owner_r;
    logic [WD_W-1:0]   wd_cnt_r;
    payload_t          payload_r;
    payload_t          req_payload_s;
    logic              grant_valid_s;
    logic [IDX_W-1:0]  grant_idx_s;

    vx_rr_picker #(
        .NUM_REQS (NUM_REQS),
        .IDX_W    (IDX_W)
    ) u_picker (
        .valid       (in_req_valid),
        .rr_ptr      (rr_ptr_r),
        .grant_valid (grant_valid_s),
        .grant_idx   (grant_idx_s)
    );

    // Select the winning requester's payload slice for latching.
    always_comb begin
        req_payload_s.rw     = in_req_rw[grant_idx_s];
        req_payload_s.addr   = in_req_addr[grant_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
        req_payload_s.data   = in_req_data[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
        req_payload_s.byteen = in_req_byteen[grant_idx_s*BE_W +: BE_W];
        req_payload_s.tag    = in_req_tag[grant_idx_s*TAG_WIDTH +: TAG_WIDTH];
    end

    // Arbitration FSM, watchdog and error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ARB;
            rr_ptr_r  <= '0;
            owner_r   <= '0;
            wd_cnt_r  <= '0;
            payload_r <= '0;
            err_valid <= 1'b0;
            err_id    <= '0;
        end else begin
            err_valid <= 1'b0;
            case (state_r)
                ARB: begin
                    if (grant_valid_s) begin
                        owner_r   <= grant_idx_s;
                        payload_r <= req_payload_s;
                        rr_ptr_r  <= IDX_W'(rr_next(int'(grant_idx_s), NUM_REQS));
                        state_r   <= ISSUE;
                    end else begin
                        state_r   <= ARB;
                    end
                end
                ISSUE: begin
                    if (out_req_ready) begin
                        wd_cnt_r <= '0;
                        state_r  <= WAIT_RSP;
                    end else begin
                        state_r  <= ISSUE;
                    end
                end
                WAIT_RSP: begin
                    // A pending response freezes the watchdog and beats a same-cycle timeout.
                    if (out_rsp_valid) begin
                        state_r <= in_rsp_ready[owner_r] ? ARB : WAIT_RSP;
                    end else if (wd_cnt_r == WD_LAST) begin
                        err_valid <= 1'b1;
                        err_id    <= owner_r;
                        wd_cnt_r  <= '0;
                        state_r   <= ARB;
                    end else begin
                        wd_cnt_r  <= wd_cnt_r + WD_W'(1);
                    end
                end
                default: begin
                    state_r <= ARB;
                end
            endcase
        end
    end

    // Grant and response routing; everything is held low while reset is asserted.
    always_comb begin
        in_req_ready  = '0;
        in_rsp_valid  = '0;
        in_rsp_data   = '0;
        in_rsp_tag    = '0;
        out_rsp_ready = 1'b0;
        if (!reset && state_r == ARB && grant_valid_s) begin
            in_req_ready[grant_idx_s] = 1'b1;
        end else if (!reset && state_r == WAIT_RSP) begin
            in_rsp_valid[owner_r] = out_rsp_valid;
            in_rsp_data           = out_rsp_data;
            in_rsp_tag            = payload_r.tag;
            out_rsp_ready         = in_rsp_ready[owner_r];
        end else begin
            in_req_ready = '0;
        end
    end

    assign out_req_valid  = !reset && (state_r == ISSUE);
    assign out_req_rw     = payload_r.rw;
    assign out_req_addr   = payload_r.addr;
    assign out_req_data   = payload_r.data;
    assign out_req_byteen = payload_r.byteen;
    assign out_req_tag    = payload_r.tag;

endmodule

// File: tb/tb_vx_ahb_mem_arbiter.sv
// Scoreboard bench for vx_ahb_mem_arbiter: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_vx_ahb_mem_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [3:0]     in_req_valid;
    logic [3:0]     in_req_rw;
    logic [103:0]   in_req_addr;
    logic [2047:0]  in_req_data;
    logic [255:0]   in_req_byteen;
    logic [31:0]    in_req_tag;
    logic [3:0]     in_req_ready;
    logic [3:0]     in_rsp_valid;
    logic [511:0]   in_rsp_data;
    logic [7:0]     in_rsp_tag;
    logic [3:0]     in_rsp_ready;
    logic           out_req_valid;
    logic           out_req_rw;
    logic [25:0]    out_req_addr;
    logic [511:0]   out_req_data;
    logic [63:0]    out_req_byteen;
    logic [7:0]     out_req_tag;
    logic           out_req_ready;
    logic           out_rsp_valid;
    logic [511:0]   out_rsp_data;
    logic           out_rsp_ready;
    logic           err_valid;
    logic [1:0]     err_id;

    vx_ahb_mem_arbiter #(
        .NUM_REQS(4), .DATA_WIDTH(512), .ADDR_WIDTH(26), .TAG_WIDTH(8), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset),
        .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_addr(in_req_addr),
        .in_req_data(in_req_data), .in_req_byteen(in_req_byteen), .in_req_tag(in_req_tag),
        .in_req_ready(in_req_ready), .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data),
        .in_rsp_tag(in_rsp_tag), .in_rsp_ready(in_rsp_ready),
        .out_req_valid(out_req_valid), .out_req_rw(out_req_rw), .out_req_addr(out_req_addr),
        .out_req_data(out_req_data), .out_req_byteen(out_req_byteen), .out_req_tag(out_req_tag),
        .out_req_ready(out_req_ready), .out_rsp_valid(out_rsp_valid), .out_rsp_data(out_rsp_data),
        .out_rsp_ready(out_rsp_ready), .err_valid(err_valid), .err_id(err_id)
    );

    always #5 clk = ~clk;

    typedef struct { logic rw; logic [25:0] addr; logic [511:0] data; logic [63:0] be; logic [7:0] tag; } iss_t;
    typedef struct { logic [3:0] oh; logic [7:0] tag; logic [511:0] data; } rsp_t;
    typedef struct { logic [1:0] id; int cyc; } err_t;

    int   exp_grant [$];
    iss_t exp_issue [$];
    rsp_t exp_rsp   [$];
    err_t exp_err   [$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic grant_prev = 1'b0;

    logic         r_rw   [N];
    logic [25:0]  r_addr [N];
    logic [511:0] r_data [N];
    logic [63:0]  r_be   [N];
    logic [7:0]   r_tag  [N];

    always @(posedge clk) cyc <= cyc + 1;

    // Pack the per-requester stimulus arrays onto the flat request buses.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            in_req_rw[i]                = r_rw[i];
            in_req_addr[i*26 +: 26]     = r_addr[i];
            in_req_data[i*512 +: 512]   = r_data[i];
            in_req_byteen[i*64 +: 64]   = r_be[i];
            in_req_tag[i*8 +: 8]        = r_tag[i];
        end
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // Monitor: pop and compare whenever the DUT presents a grant, issue, response or error.
    always @(negedge clk) begin
        if (reset) begin
            grant_prev = 1'b0;
        end else begin
            if (grant_prev) chk("issue_latency", 512'(out_req_valid), 512'(1'b1));
            if (|in_req_ready) begin
                chk("single_outstanding", 512'(out_req_valid), 512'(1'b0));
                if (exp_grant.size() == 0) fail_now("unexpected_grant");
                else chk("grant_onehot", 512'(in_req_ready), 512'(4'b0001 << exp_grant.pop_front()));
            end
            grant_prev = |in_req_ready;
            if (out_req_valid && out_req_ready) begin
                if (exp_issue.size() == 0) fail_now("unexpected_issue");
                else begin
                    iss_t e;
                    e = exp_issue.pop_front();
                    chk("issue_rw", 512'(out_req_rw), 512'(e.rw));
                    chk("issue_addr", 512'(out_req_addr), 512'(e.addr));
                    chk("issue_data", out_req_data, e.data);
                    chk("issue_byteen", 512'(out_req_byteen), 512'(e.be));
                    chk("issue_tag", 512'(out_req_tag), 512'(e.tag));
                end
            end
            if (|(in_rsp_valid & in_rsp_ready)) begin
                if (exp_rsp.size() == 0) fail_now("unexpected_rsp");
                else begin
                    rsp_t r;
                    r = exp_rsp.pop_front();
                    chk("rsp_valid", 512'(in_rsp_valid), 512'(r.oh));
                    chk("rsp_tag", 512'(in_rsp_tag), 512'(r.tag));
                    chk("rsp_data", in_rsp_data, r.data);
                end
            end else if (|in_rsp_valid && exp_rsp.size() == 0) begin
                fail_now("unexpected_rsp_valid");
            end
            if (err_valid) begin
                if (exp_err.size() == 0) fail_now("unexpected_err");
                else begin
                    err_t x;
                    x = exp_err.pop_front();
                    chk("err_id", 512'(err_id), 512'(x.id));
                    chk("err_cycle", 512'(cyc), 512'(x.cyc));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic rw, input logic [25:0] a, input logic [511:0] d,
                           input logic [63:0] be, input logic [7:0] t);
        r_rw[i] = rw; r_addr[i] = a; r_data[i] = d; r_be[i] = be; r_tag[i] = t;
    endtask

    task automatic push_issue(input int i);
        iss_t e;
        e.rw = r_rw[i]; e.addr = r_addr[i]; e.data = r_data[i]; e.be = r_be[i]; e.tag = r_tag[i];
        exp_issue.push_back(e);
    endtask

    task automatic push_rsp(input int i, input logic [511:0] d);
        rsp_t r;
        r.oh = 4'b0001 << i; r.tag = r_tag[i]; r.data = d;
        exp_rsp.push_back(r);
    endtask

    task automatic wait_grant(input int i);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!in_req_ready[i] && n < 40);
        if (!in_req_ready[i]) fail_now("grant_timeout");
        tick();
        in_req_valid[i] = 1'b0;
    endtask

    task automatic wait_issue();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_req_valid && n < 40);
        if (!out_req_valid) fail_now("issue_timeout");
        tick();
    endtask

    task automatic respond(input logic [511:0] d);
        int n;
        out_rsp_valid = 1'b1;
        out_rsp_data  = d;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_rsp_ready && n < 40);
        if (!out_rsp_ready) fail_now("rsp_handshake_timeout");
        tick();
        out_rsp_valid = 1'b0;
        out_rsp_data  = '0;
    endtask

    task automatic txn(input int i, input logic rw, input logic [25:0] a, input logic [511:0] d,
                       input logic [63:0] be, input logic [7:0] t, input logic [511:0] rsp, input int gap);
        set_req(i, rw, a, d, be, t);
        exp_grant.push_back(i);
        push_issue(i);
        in_req_valid[i] = 1'b1;
        wait_grant(i);
        wait_issue();
        repeat (gap) tick();
        push_rsp(i, rsp);
        respond(rsp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 512'(in_req_ready), 512'(4'b0));
        chk({tag, "_rsp_valid"}, 512'(in_rsp_valid), 512'(4'b0));
        chk({tag, "_rsp_data"}, in_rsp_data, 512'(1'b0));
        chk({tag, "_rsp_tag"}, 512'(in_rsp_tag), 512'(8'h0));
        chk({tag, "_out_valid"}, 512'(out_req_valid), 512'(1'b0));
        chk({tag, "_out_addr"}, 512'(out_req_addr), 512'(26'h0));
        chk({tag, "_out_data"}, out_req_data, 512'(1'b0));
        chk({tag, "_out_tag"}, 512'(out_req_tag), 512'(8'h0));
        chk({tag, "_rsp_ready"}, 512'(out_rsp_ready), 512'(1'b0));
        chk({tag, "_err"}, 512'(err_valid), 512'(1'b0));
    endtask

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        int w0;
        reset = 1'b1; in_req_valid = '0; in_rsp_ready = 4'hF;
        out_req_ready = 1'b1; out_rsp_valid = 1'b0; out_rsp_data = '0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 26'h0, 512'h0, 64'h0, 8'h0);
        repeat (3) tick();
        @(negedge clk);
        chk_all_zero("reset");
        tick();
        reset = 1'b0;

        // Round robin from rr_ptr = 0 with all requesters valid, including the 3 -> 0 wrap.
        for (int i = 0; i < N; i++)
            set_req(i, 1'b0, 26'h10 + 26'(i), {16{32'h1111_0000 + 32'(i)}}, 64'hFFFF_FFFF_FFFF_FFFF, 8'hA0 + 8'(i));
        for (int k = 0; k < 5; k++) begin
            exp_grant.push_back(order[k]);
            push_issue(order[k]);
        end
        in_req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_issue();
            if (k == 4) in_req_valid = '0;
            tick();
            push_rsp(order[k], {16{32'hC0DE_0000 + 32'(k)}});
            respond({16{32'hC0DE_0000 + 32'(k)}});
        end

        // Write from requester 1, then the single read from requester 2.
        txn(1, 1'b1, 26'h2ABCDE, {8{64'h0123_4567_89AB_CDEF}}, 64'hFFFF_0000_FFFF_00FF, 8'h33, 512'h0, 0);
        txn(2, 1'b0, 26'h000100, 512'h0, 64'h0, 8'h5A, {16{32'hDEAD_BEEF}}, 2);

        // Adapter response outside WAIT_RSP must be ignored.
        out_rsp_valid = 1'b1; out_rsp_data = {16{32'hBAD0_BAD0}};
        repeat (2) begin
            @(negedge clk);
            chk("idle_rsp_ready", 512'(out_rsp_ready), 512'(1'b0));
            chk("idle_rsp_valid", 512'(in_rsp_valid), 512'(4'b0));
            tick();
        end
        out_rsp_valid = 1'b0; out_rsp_data = '0;

        // Backpressure on requester 3 long enough to exceed the timeout if the watchdog ran.
        set_req(3, 1'b0, 26'h3F_0000, 512'h0, 64'h1, 8'hC3);
        exp_grant.push_back(3); push_issue(3);
        in_req_valid[3] = 1'b1;
        wait_grant(3);
        wait_issue();
        repeat (12) tick();
        push_rsp(3, {16{32'h5555_AAAA}});
        in_rsp_ready[3] = 1'b0;
        out_rsp_valid = 1'b1; out_rsp_data = {16{32'h5555_AAAA}};
        repeat (6) begin
            @(negedge clk);
            chk("bp_rsp_valid", 512'(in_rsp_valid), 512'(4'b1000));
            chk("bp_rsp_data", in_rsp_data, {16{32'h5555_AAAA}});
            chk("bp_rsp_ready", 512'(out_rsp_ready), 512'(1'b0));
            chk("bp_no_err", 512'(err_valid), 512'(1'b0));
            tick();
        end
        in_rsp_ready[3] = 1'b1;
        respond({16{32'h5555_AAAA}});

        // Timeout: requester 0, adapter silent; err pulse 16 cycles into WAIT_RSP.
        set_req(0, 1'b0, 26'h00_0777, 512'h0, 64'h0, 8'h77);
        exp_grant.push_back(0); push_issue(0);
        in_req_valid[0] = 1'b1;
        wait_grant(0);
        wait_issue();
        w0 = cyc;
        exp_err.push_back('{id: 2'd0, cyc: w0 + 16});
        repeat (20) tick();
        chk("timeout_err_seen", 512'(exp_err.size()), 512'(0));
        txn(2, 1'b0, 26'h00_0222, 512'h0, 64'h0, 8'h22, {16{32'h2222_2222}}, 1);

        // Response arriving exactly at the last watchdog count wins over the abort.
        txn(3, 1'b0, 26'h00_0333, 512'h0, 64'h0, 8'h3E, {16{32'h3333_0F0F}}, 15);

        // Reset while requester 1 waits for a response.
        set_req(1, 1'b0, 26'h00_0111, 512'h0, 64'h0, 8'h11);
        exp_grant.push_back(1); push_issue(1);
        in_req_valid[1] = 1'b1;
        wait_grant(1);
        wait_issue();
        repeat (3) tick();
        reset = 1'b1;
        in_req_valid = 4'hF;
        set_req(0, 1'b1, 26'h00_0ABC, {16{32'hFACE_0000}}, 64'hF0F0_F0F0_F0F0_F0F0, 8'hE0);
        @(negedge clk);
        chk("rst_req_ready", 512'(in_req_ready), 512'(4'b0));
        tick();
        @(negedge clk);
        chk_all_zero("midrst");
        tick();
        exp_grant.push_back(0); push_issue(0);
        reset = 1'b0;
        wait_grant(0);
        in_req_valid = '0;
        wait_issue();
        push_rsp(0, 512'h0);
        respond(512'h0);

        repeat (5) tick();
        chk("queues_empty", 512'(exp_grant.size() + exp_issue.size() + exp_rsp.size() + exp_err.size()), 512'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
